// File: rtl/test_monitor.sv
// ---------------------------------------------------------------------------
// test_monitor
//
// End-of-test monitor for riscv-tests runs on the pipelined core. It watches
// the fetch PC and the register-file writeback port and keeps a shadow copy
// of the result register (gp/x3 by default). When the halt address is
// fetched, it reports pass or fail, including the failing test number. If
// the run never reaches the halt address, it reports timeout.
//
// Optional feature (macro TEST_MONITOR_TOHOST_EN):
//   Adds a store-snoop port. A store to TOHOST_ADDR while running is a
//   second halt source, and the verdict is taken from the stored data.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   one-cycle pulse: clear results and (re)arm the monitor
//   pc_valid   in   pc carries a real fetch this cycle
//   pc         in   fetch-stage PC
//   wb_en      in   register-file write this cycle
//   wb_addr    in   destination register index
//   wb_data    in   write data
//   mem_we     in   data store strobe        (TEST_MONITOR_TOHOST_EN only)
//   mem_addr   in   data store address       (TEST_MONITOR_TOHOST_EN only)
//   mem_wdata  in   data store write data    (TEST_MONITOR_TOHOST_EN only)
//   done       out  run finished (sticky until start/rst)
//   pass       out  finished with result value == 1
//   fail       out  finished with result value != 1
//   timeout    out  finished because the cycle budget ran out
//   fail_test  out  result value >> 1 on fail, else 0
//   cycles     out  number of RUN cycles elapsed
// ---------------------------------------------------------------------------
module test_monitor #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] HALT_PC     = XLEN'(32'h44),
    parameter int              RESULT_REG  = 3,
    parameter int              TIMEOUT     = 6000,
    parameter int              CNT_W       = 16,
    parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(32'h1000)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pc_valid,
    input  logic [XLEN-1:0]  pc,
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    input  logic [XLEN-1:0]  wb_data,
`ifdef TEST_MONITOR_TOHOST_EN
    input  logic             mem_we,
    input  logic [XLEN-1:0]  mem_addr,
    input  logic [XLEN-1:0]  mem_wdata,
`endif
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [XLEN-1:0]  fail_test,
    output logic [CNT_W-1:0] cycles
);

    localparam logic [4:0]       RES_ADDR = 5'(RESULT_REG);
    // Count value at the start of the last permitted RUN cycle.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] shadow;

    logic            wr_hit;
    logic            halt_pc;
    logic            halt_any;
    logic [XLEN-1:0] shadow_nxt;
    logic [XLEN-1:0] verdict_val;

    // The shadow value that is judged includes a qualifying write landing in
    // the same cycle as the halt fetch. The write may still be in flight in
    // the pipeline when the halt address is fetched.
    always_comb begin
        wr_hit      = wb_en && (wb_addr == RES_ADDR) && (wb_addr != 5'd0);
        shadow_nxt  = wr_hit ? wb_data : shadow;
        halt_pc     = pc_valid && (pc == HALT_PC);
        halt_any    = halt_pc;
        verdict_val = shadow_nxt;
`ifdef TEST_MONITOR_TOHOST_EN
        // A tohost store carries the verdict directly. It overrides the
        // shadow when both halt sources fire in the same cycle.
        if (mem_we && (mem_addr == TOHOST_ADDR)) begin
            halt_any    = 1'b1;
            verdict_val = mem_wdata;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shadow    <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
            fail_test <= '0;
            cycles    <= '0;
        end else if (start) begin
            // A start pulse rearms from any state and wipes the last verdict.
            state     <= RUN;
            shadow    <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
            fail_test <= '0;
            cycles    <= '0;
        end else begin
            case (state)
                IDLE: begin
                end
                RUN: begin
                    // The halt cycle itself is counted.
                    cycles <= cycles + CNT_W'(1);
                    shadow <= shadow_nxt;
                    if (halt_any) begin
                        state <= DONE;
                        done  <= 1'b1;
                        if (verdict_val == XLEN'(1)) begin
                            pass <= 1'b1;
                        end else begin
                            fail      <= 1'b1;
                            fail_test <= verdict_val >> 1;
                        end
                    end else if (cycles == TMO_LAST) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                DONE: begin
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_test_monitor.sv
module tb_test_monitor;

    localparam int          XLEN       = 32;
    localparam int          CNT_W      = 16;
    localparam int          TB_TIMEOUT = 50;
    localparam logic [31:0] HALT       = 32'h44;
    localparam logic [31:0] TOHOST     = 32'h1000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             pc_valid = 1'b0;
    logic [XLEN-1:0]  pc = '0;
    logic             wb_en = 1'b0;
    logic [4:0]       wb_addr = '0;
    logic [XLEN-1:0]  wb_data = '0;
`ifdef TEST_MONITOR_TOHOST_EN
    logic             mem_we = 1'b0;
    logic [XLEN-1:0]  mem_addr = '0;
    logic [XLEN-1:0]  mem_wdata = '0;
`endif
    logic             done;
    logic             pass;
    logic             fail;
    logic             timeout;
    logic [XLEN-1:0]  fail_test;
    logic [CNT_W-1:0] cycles;

    test_monitor #(
        .XLEN(XLEN), .HALT_PC(HALT), .RESULT_REG(3), .TIMEOUT(TB_TIMEOUT),
        .CNT_W(CNT_W), .TOHOST_ADDR(TOHOST)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pc_valid(pc_valid), .pc(pc),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
`ifdef TEST_MONITOR_TOHOST_EN
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`endif
        .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .fail_test(fail_test), .cycles(cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    // Reference model: a plain description of a test run.
    bit          m_running;
    int          m_count;
    logic [31:0] m_x3;
    bit          e_done, e_pass, e_fail, e_timeout;
    logic [31:0] e_ft;
    int          e_cycles;
    bit          p_done, p_pass, p_fail, p_timeout;
    logic [31:0] p_ft;
    int          p_cycles;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_running = 0; m_count = 0; m_x3 = 0;
        e_done = 0; e_pass = 0; e_fail = 0; e_timeout = 0; e_ft = 0; e_cycles = 0;
    endtask

    task automatic judge(input logic [31:0] v);
        m_running = 0;
        p_done = 1;
        if (v == 32'd1) p_pass = 1;
        else begin p_fail = 1; p_ft = v / 2; end
    endtask

    // Predict what the outputs must show after the coming clock edge.
    task automatic model_step();
        p_done = e_done; p_pass = e_pass; p_fail = e_fail; p_timeout = e_timeout;
        p_ft = e_ft; p_cycles = e_cycles;
        if (start) begin
            m_running = 1; m_count = 0; m_x3 = 0;
            p_done = 0; p_pass = 0; p_fail = 0; p_timeout = 0; p_ft = 0; p_cycles = 0;
        end else if (m_running) begin
            m_count++;
            if (wb_en && wb_addr == 5'd3) m_x3 = wb_data;
            p_cycles = m_count;
`ifdef TEST_MONITOR_TOHOST_EN
            if (mem_we && mem_addr == TOHOST) judge(mem_wdata);
            else
`endif
            if (pc_valid && pc == HALT) judge(m_x3);
            else if (m_count == TB_TIMEOUT) begin
                m_running = 0; p_done = 1; p_timeout = 1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("done", done, e_done);
            chk("pass", pass, e_pass);
            chk("fail", fail, e_fail);
            chk("timeout", timeout, e_timeout);
            chk("fail_test", fail_test, e_ft);
            chk("cycles", cycles, e_cycles[CNT_W-1:0]);
        end
    end

    task automatic set_idle();
        start = 0; pc_valid = 0; pc = 32'h0; wb_en = 0; wb_addr = 0; wb_data = 0;
`ifdef TEST_MONITOR_TOHOST_EN
        mem_we = 0; mem_addr = 0; mem_wdata = 0;
`endif
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        e_done = p_done; e_pass = p_pass; e_fail = p_fail; e_timeout = p_timeout;
        e_ft = p_ft; e_cycles = p_cycles;
        #1;
        set_idle();
    endtask

    task automatic fetch(input int i);
        pc_valid = 1; pc = 32'h100 + 32'(4 * i);
    endtask

    task automatic do_start();
        start = 1; tick();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1; wb_addr = a; wb_data = d;
    endtask

    initial begin
        set_idle();
        model_clear();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        cmp_en = 1;
        chk("rst_done", done, 0);
        chk("rst_cycles", cycles, 0);
        repeat (2) tick();

        // Pass at RUN cycle 20.
        do_start();
        for (int i = 1; i <= 20; i++) begin
            fetch(i);
            if (i == 3) wr(5'd3, 32'd1);
            if (i == 20) pc = HALT;
            tick();
        end
        chk("t1_done", done, 1);
        chk("t1_pass", pass, 1);
        chk("t1_cycles", cycles, 20);
        // Inputs are ignored while DONE.
        pc_valid = 1; pc = HALT; wr(5'd3, 32'd7); tick();
        repeat (2) tick();
        chk("t1_frozen_pass", pass, 1);
        chk("t1_frozen_cycles", cycles, 20);

        // Fail with test number 3; x5/x0 writes and a non-valid halt PC are ignored.
        do_start();
        chk("rearm_done", done, 0);
        chk("rearm_cycles", cycles, 0);
        for (int i = 1; i <= 6; i++) begin
            fetch(i);
            if (i == 2) wr(5'd3, 32'd7);
            if (i == 3) wr(5'd5, 32'd1);
            if (i == 4) wr(5'd0, 32'd1);
            if (i == 5) begin pc_valid = 0; pc = HALT; end
            if (i == 6) pc = HALT;
            tick();
        end
        chk("t2_fail", fail, 1);
        chk("t2_fail_test", fail_test, 3);
        chk("t2_cycles", cycles, 6);

        // Same-cycle write bypass decides the verdict.
        do_start();
        for (int i = 1; i <= 4; i++) begin
            fetch(i);
            if (i == 1) wr(5'd3, 32'd9);
            if (i == 4) begin pc = HALT; wr(5'd3, 32'd1); end
            tick();
        end
        chk("t3_pass", pass, 1);
        chk("t3_fail", fail, 0);

        // Timeout after exactly TB_TIMEOUT RUN cycles.
        do_start();
        for (int i = 1; i <= TB_TIMEOUT; i++) begin fetch(i); tick(); end
        chk("t4_timeout", timeout, 1);
        chk("t4_pass", pass, 0);
        chk("t4_cycles", cycles, 50);
        repeat (2) tick();

        // Halt on the last budget cycle beats timeout.
        do_start();
        for (int i = 1; i <= TB_TIMEOUT; i++) begin
            fetch(i);
            if (i == 1) wr(5'd3, 32'd1);
            if (i == TB_TIMEOUT) pc = HALT;
            tick();
        end
        chk("t5_pass", pass, 1);
        chk("t5_timeout", timeout, 0);
        chk("t5_cycles", cycles, 50);

        // Reset in the middle of a run.
        do_start();
        for (int i = 1; i <= 10; i++) begin fetch(i); wr(5'd3, 32'd1); tick(); end
        rst = 1;
        model_clear();
        #1;
        chk("t6_rst_done", done, 0);
        chk("t6_rst_cycles", cycles, 0);
        @(posedge clk);
        #1;
        rst = 0;
        // A halt while IDLE must not produce a verdict.
        pc_valid = 1; pc = HALT; tick();
        chk("t6_idle_done", done, 0);

        // Restart while running.
        do_start();
        for (int i = 1; i <= 5; i++) begin fetch(i); wr(5'd3, 32'd11); tick(); end
        do_start();
        for (int i = 1; i <= 3; i++) begin fetch(i); tick(); end
        chk("t7_cycles", cycles, 3);
        pc_valid = 1; pc = HALT; tick();
        chk("t7_fail_test", fail_test, 0);
        chk("t7_fail", fail, 1);

`ifdef TEST_MONITOR_TOHOST_EN
        do_start();
        fetch(1); tick();
        mem_we = 1; mem_addr = TOHOST; mem_wdata = 32'h5; tick();
        chk("th_fail", fail, 1);
        chk("th_fail_test", fail_test, 2);
        do_start();
        mem_we = 1; mem_addr = 32'h1004; mem_wdata = 32'h5; tick();
        mem_we = 1; mem_addr = TOHOST; mem_wdata = 32'h1; tick();
        chk("th_pass", pass, 1);
        chk("th_cycles", cycles, 2);
        do_start();
        wr(5'd3, 32'd1); tick();
        pc_valid = 1; pc = HALT; mem_we = 1; mem_addr = TOHOST; mem_wdata = 32'h9; tick();
        chk("th_prio_fail_test", fail_test, 4);
`endif

        repeat (2) tick();
        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
